conv_layer_engine: RTL and testbench

Parametrised 2-D convolution engine for the LeNet accelerator datapath. It supersedes the fixed single-layer, two-kernel convolution stage. It captures one multi-bit image and NUM_KERNELS signed kernels plus biases on a start command, then computes all output positions with zero padding, arithmetic shift, optional ReLU and saturation. Results are streamed one position at a time, all kernels in parallel, to the next stage (pooling) over a valid/ready handshake.

---
 rtl/conv_layer_engine.sv | 203 ++++++++++++++++++++
 tb/tb_conv_layer_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_engine.sv
// conv_layer_engine: K x K multi-channel 2-D convolution with zero padding,
// arithmetic shift, optional ReLU and saturation, streamed per output position.
module conv_layer_engine #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int K           = 5,
  parameter int PAD         = 2,
  parameter int NUM_KERNELS = 2,
  parameter int PIX_W       = 8,
  parameter int WGT_W       = 8,
  parameter int ACC_W       = 24,
  parameter int SHIFT       = 4,
  parameter int OUT_BITS    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic relu_en,
  input  logic [IMG_W*IMG_H*PIX_W-1:0] image,
  input  logic [NUM_KERNELS*K*K*WGT_W-1:0] kernels,
  input  logic [NUM_KERNELS*WGT_W-1:0] biases,
  output logic busy,
  output logic out_valid,
  input  logic out_ready,
  output logic [NUM_KERNELS*OUT_BITS-1:0] out_data,
  output logic [$clog2(IMG_H+2*PAD-K+1)-1:0] out_row,
  output logic [$clog2(IMG_W+2*PAD-K+1)-1:0] out_col,
  output logic done
);

  localparam int OUT_ROWS = IMG_H + 2*PAD - K + 1;
  localparam int OUT_COLS = IMG_W + 2*PAD - K + 1;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NTAP = K * K;
  localparam int RW = $clog2(OUT_ROWS);
  localparam int CW = $clog2(OUT_COLS);
  localparam int TW = $clog2(NTAP);
  localparam int KW = $clog2(K);
  localparam int PW = $clog2(NPIX);
  localparam int PRW = PIX_W + WGT_W + 1;
  localparam logic signed [15:0] IH = 16'(IMG_H);
  localparam logic signed [15:0] IW = 16'(IMG_W);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((64'sd1 <<< (OUT_BITS-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [KW-1:0] r_q, r_d, s_q, s_d;
  logic relu_q, relu_d;
  logic [NUM_KERNELS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic signed [ACC_W-1:0] acc_q [NUM_KERNELS];
  logic signed [ACC_W-1:0] acc_d [NUM_KERNELS];
  logic [PIX_W-1:0] img_q [NPIX];
  logic [PIX_W-1:0] img_d [NPIX];
  logic signed [WGT_W-1:0] wgt_q [NUM_KERNELS][NTAP];
  logic signed [WGT_W-1:0] wgt_d [NUM_KERNELS][NTAP];
  logic signed [WGT_W-1:0] bias_q [NUM_KERNELS];
  logic signed [WGT_W-1:0] bias_d [NUM_KERNELS];

  logic signed [15:0] iy, ix, lin;
  logic in_img;
  logic [PIX_W-1:0] pix;
  logic signed [PRW-1:0] prod [NUM_KERNELS];
  logic signed [ACC_W-1:0] acc_n [NUM_KERNELS];
  logic signed [ACC_W-1:0] v;
  logic [NUM_KERNELS*OUT_BITS-1:0] res;

  // Padding taps read as zero instead of touching the image store.
  always_comb begin
    iy = 16'(row_q) + 16'(r_q) - 16'(PAD);
    ix = 16'(col_q) + 16'(s_q) - 16'(PAD);
    in_img = !iy[15] && (iy < IH) && !ix[15] && (ix < IW);
    lin = iy * IW + ix;
    pix = in_img ? img_q[PW'(lin)] : '0;
  end

  always_comb begin
    v = '0;
    res = '0;
    for (int c = 0; c < NUM_KERNELS; c++) begin
      prod[c] = $signed({1'b0, pix}) * wgt_q[c][tap_q];
      acc_n[c] = acc_q[c] + ACC_W'(prod[c]);
      v = acc_n[c] >>> SHIFT;
      if (relu_q && v[ACC_W-1]) v = '0;
      if (v > SAT_MAX) v = SAT_MAX;
      else if (v < SAT_MIN) v = SAT_MIN;
      res[c*OUT_BITS +: OUT_BITS] = OUT_BITS'(v);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    tap_d = tap_q;
    r_d = r_q;
    s_d = s_q;
    relu_d = relu_q;
    out_data_d = out_data_q;
    acc_d = acc_q;
    img_d = img_q;
    wgt_d = wgt_q;
    bias_d = bias_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        for (int i = 0; i < NPIX; i++)
          img_d[i] = image[i*PIX_W +: PIX_W];
        for (int c = 0; c < NUM_KERNELS; c++) begin
          bias_d[c] = $signed(biases[c*WGT_W +: WGT_W]);
          acc_d[c] = ACC_W'($signed(biases[c*WGT_W +: WGT_W]));
          for (int t = 0; t < NTAP; t++)
            wgt_d[c][t] = $signed(kernels[(c*NTAP+t)*WGT_W +: WGT_W]);
        end
        relu_d = relu_en;
        row_d = '0;
        col_d = '0;
        tap_d = '0;
        r_d = '0;
        s_d = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_n;
        if (tap_q == TW'(NTAP-1)) begin
          out_data_d = res;
          state_d = S_OUT;
        end else begin
          tap_d = tap_q + 1'b1;
          if (s_q == KW'(K-1)) begin
            s_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      S_OUT: if (out_ready) begin
        if (row_q == RW'(OUT_ROWS-1) && col_q == CW'(OUT_COLS-1)) begin
          state_d = S_DONE;
        end else begin
          if (col_q == CW'(OUT_COLS-1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          for (int c = 0; c < NUM_KERNELS; c++)
            acc_d[c] = ACC_W'(bias_q[c]);
          tap_d = '0;
          r_d = '0;
          s_d = '0;
          state_d = S_MAC;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q <= '0;
      col_q <= '0;
      tap_q <= '0;
      r_q <= '0;
      s_q <= '0;
      relu_q <= 1'b0;
      out_data_q <= '0;
      for (int c = 0; c < NUM_KERNELS; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      tap_q <= tap_d;
      r_q <= r_d;
      s_q <= s_d;
      relu_q <= relu_d;
      out_data_q <= out_data_d;
      acc_q <= acc_d;
    end
  end

  // Operand stores only change on an accepted start.
  always_ff @(posedge clk) begin
    img_q <= img_d;
    wgt_q <= wgt_d;
    bias_q <= bias_d;
  end

  assign busy = (state_q == S_MAC) || (state_q == S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign done = (state_q == S_DONE);
  assign out_data = out_data_q;
  assign out_row = row_q;
  assign out_col = col_q;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine: delta/ramp, padding, sign/ReLU/saturation,
// backpressure, mid-job reset and start-while-busy.
module tb_conv_layer_engine;
  localparam int NPIX = 784;
  localparam int NTAP = 25;
  localparam int NK = 2;
  localparam int OB = 16;

  logic clk = 1'b0;
  logic reset, start, relu_en, out_ready;
  logic [NPIX*8-1:0] image;
  logic [NK*NTAP*8-1:0] kernels;
  logic [NK*8-1:0] biases;
  logic busy, out_valid, done;
  logic [NK*OB-1:0] out_data;
  logic [4:0] out_row, out_col;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int r_nsmp, r_ndone, r_tdone, r_tfirst;
  int got0 [NPIX];

  conv_layer_engine #(.SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .image(image), .kernels(kernels), .biases(biases),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] ch(input int c);
    return $signed(out_data[c*OB +: OB]);
  endfunction

  function automatic int cnt1(input int p);
    int lo, hi;
    lo = (p - 2 < 0) ? 0 : p - 2;
    hi = (p + 2 > 27) ? 27 : p + 2;
    return hi - lo + 1;
  endfunction

  // mode 0: ramp image, delta kernels; mode 1: ones image, flat kernels
  function automatic int expv(input int mode, input int c, input int r, input int col);
    int p, n;
    p = (r*28 + col) % 256;
    n = cnt1(r) * cnt1(col);
    if (mode == 0) return (c == 0) ? p : 2*p + 3;
    return (c == 0) ? n : 5 - n;
  endfunction

  // img: 0 ramp, 1 ones, 2 all 255, 3 zeros
  task automatic set_inputs(input int img, input int w0, input int w1,
                            input int b0, input int b1, input bit delta);
    for (int i = 0; i < NPIX; i++)
      image[i*8 +: 8] = (img == 0) ? 8'(i % 256) : (img == 1) ? 8'd1 :
                        (img == 2) ? 8'd255 : 8'd0;
    for (int t = 0; t < NTAP; t++) begin
      kernels[t*8 +: 8] = (!delta || t == 12) ? 8'(w0) : 8'd0;
      kernels[(NTAP+t)*8 +: 8] = (!delta || t == 12) ? 8'(w1) : 8'd0;
    end
    biases = {8'(b1), 8'(b0)};
  endtask

  task automatic do_start(input bit relu, output int t0);
    @(negedge clk);
    relu_en = relu;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input int mode, input bit bp, input int t0);
    bit stalled;
    logic [NK*OB-1:0] hd;
    logic [4:0] hr, hc;
    stalled = 1'b0;
    hd = '0; hr = '0; hc = '0;
    r_nsmp = 0; r_ndone = 0; r_tdone = -1; r_tfirst = -1;
    for (int i = 0; i < NPIX; i++) got0[i] = -1;
    for (int k = 0; k < 30000; k++) begin
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hd);
        chk("stall_row", out_row, hr);
        chk("stall_col", out_col, hc);
      end
      if (done) begin
        r_ndone++;
        r_tdone = cyc - t0;
        chk("done_busy", busy, 0);
      end
      if (mode == 0 && cyc - t0 == 100) begin
        set_inputs(3, 5, 5, 9, 9, 0);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (out_valid && r_tfirst < 0) r_tfirst = cyc - t0;
      stalled = out_valid && !out_ready;
      hd = out_data; hr = out_row; hc = out_col;
      if (out_valid && out_ready) begin
        chk("row", out_row, r_nsmp / 28);
        chk("col", out_col, r_nsmp % 28);
        chk("ch0", ch(0), expv(mode, 0, r_nsmp / 28, r_nsmp % 28));
        chk("ch1", ch(1), expv(mode, 1, r_nsmp / 28, r_nsmp % 28));
        if (r_nsmp < NPIX) got0[r_nsmp] = int'(ch(0));
        r_nsmp++;
      end
      if (r_ndone > 0 && cyc - t0 >= r_tdone + 3) break;
      @(negedge clk);
    end
  endtask

  task automatic sat_case(input string tag, input bit relu, input int w0,
                          input int b0, input int w1, input int e0, input int e1);
    int t0;
    set_inputs(2, w0, w1, b0, 0, 0);
    out_ready = 1'b1;
    do_start(relu, t0);
    for (int k = 0; k < 3000; k++) begin
      if (out_valid && out_row == 5'd2 && out_col == 5'd2) break;
      @(negedge clk);
    end
    chk({tag, "_pos"}, out_valid && out_row == 5'd2 && out_col == 5'd2, 1);
    chk({tag, "_ch0"}, ch(0), e0);
    chk({tag, "_ch1"}, ch(1), e1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int t0, bad;
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
    set_inputs(3, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);

    // delta kernel on ramp image, with a second start ignored at cycle 100
    set_inputs(0, 1, 2, 0, 3, 1);
    do_start(1'b0, t0);
    chk("A_busy_c1", busy, 1);
    chk("A_valid_c1", out_valid, 0);
    run_stream(0, 1'b0, t0);
    chk("A_count", r_nsmp, 784);
    chk("A_done_once", r_ndone, 1);
    chk("A_done_cycle", r_tdone, 20385);
    chk("A_first_valid", r_tfirst, 26);
    chk("A_idle_busy", busy, 0);

    sat_case("neg_sat", 1'b0, -128, -1, 1, -32768, 6375);
    sat_case("relu", 1'b1, -128, -1, 1, 0, 6375);
    sat_case("pos_sat", 1'b0, 127, 0, -1, 32767, -6375);

    // reset in cycle 500 discards the job
    set_inputs(0, 1, 2, 0, 3, 1);
    out_ready = 1'b1;
    do_start(1'b0, t0);
    while (cyc - t0 < 500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_done", done, 0);
    chk("mid_data", out_data, 0);
    chk("mid_row", out_row, 0);
    chk("mid_col", out_col, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || out_valid || busy) bad++;
    end
    chk("mid_quiet", bad, 0);

    // fresh padding job under random backpressure
    set_inputs(1, 1, -1, 0, 5, 0);
    do_start(1'b0, t0);
    run_stream(1, 1'b1, t0);
    chk("B_count", r_nsmp, 784);
    chk("B_done_once", r_ndone, 1);
    chk("pad_0_0", got0[0], 9);
    chk("pad_0_1", got0[1], 12);
    chk("pad_0_2", got0[2], 15);
    chk("pad_14_14", got0[14*28+14], 25);
    chk("pad_27_27", got0[783], 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
